wbslave_fifo: RTL and testbench

- Wishbone classic slave sitting directly downstream of the bus master; answers the master's single-word reads at DATA_ADDR.
- Data comes from an internal FIFO filled by a local producer over a valid/ready port.
- Also provides a status/control register and raises INTR_I-compatible interrupt when data is pending.
- ERR_O is driven on illegal accesses; the master treats ERR as a reset of its own FSM.

---
 rtl/wbslave_fifo_pkg.sv | 41 ++++
 rtl/wbslave_fifo_core.sv | 63 ++++++
 rtl/wbslave_fifo.sv | 119 +++++++++++
 tb/tb_wbslave_fifo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wbslave_fifo_pkg.sv
// Shared widths, bus addresses, status-register layout and FSM/decode types
// for the Wishbone FIFO slave.
package wbslave_fifo_pkg;

    localparam int ADDRESS_WIDTH = 8;
    localparam int DATA_WIDTH    = 8;
    localparam int SELECT_WIDTH  = 1;

    localparam logic [7:0] DATA_ADDR_DEF = 8'hFF;
    localparam logic [7:0] STAT_ADDR_DEF = 8'hFE;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_COUNT_LSB = 4;
    localparam int CTRL_FLUSH_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        WAIT_END
    } wb_state_t;

    typedef enum logic [1:0] {
        ACC_ILLEGAL,
        ACC_READ_DATA,
        ACC_READ_STAT,
        ACC_WRITE_STAT
    } access_t;

    function automatic logic [7:0] status_word(input logic [3:0] count,
                                               input logic       full,
                                               input logic       empty);
        logic [7:0] w;
        w = '0;
        w[STAT_COUNT_LSB +: 4] = count;
        w[STAT_FULL_BIT]       = full;
        w[STAT_EMPTY_BIT]      = empty;
        return w;
    endfunction

endpackage

// File: rtl/wbslave_fifo_core.sv
// FIFO storage with wrap-bit pointers; flush clears both pointers and
// overrides any push or pop on the same edge.
module wbslave_fifo_core
    import wbslave_fifo_pkg::*;
#(
    parameter int DW         = DATA_WIDTH,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  push,
    input  logic [DW-1:0]         push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DW-1:0]         head_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  empty_nxt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DW-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0] wr_ptr_nxt, rd_ptr_nxt;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + 1'b1;
            if (pop)  rd_ptr_nxt = rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // NOTE: the storage array has no reset; empty/full come from the pointers,
    // so stale contents are never observable and the array maps to plain RAM.
    always_ff @(posedge CLK_I) begin
        if (push && !flush) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign count     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                       (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);

endmodule

// File: rtl/wbslave_fifo.sv
// Wishbone classic slave: single-cycle registered ACK/ERR per strobe, FIFO
// read port, status/flush register and a level interrupt while data waits.
module wbslave_fifo
    import wbslave_fifo_pkg::*;
#(
    parameter int            AW         = ADDRESS_WIDTH,
    parameter int            DW         = DATA_WIDTH,
    parameter int            SW         = SELECT_WIDTH,
    parameter logic [AW-1:0] DATA_ADDR  = AW'(DATA_ADDR_DEF),
    parameter logic [AW-1:0] STAT_ADDR  = AW'(STAT_ADDR_DEF),
    parameter int            DEPTH_LOG2 = 3
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [AW-1:0] ADR_I,
    input  logic [DW-1:0] DAT_I,
    output logic [DW-1:0] DAT_O,
    input  logic          WE_I,
    input  logic [SW-1:0] SEL_I,
    input  logic          STB_I,
    input  logic          CYC_I,
    output logic          ACK_O,
    output logic          ERR_O,
    output logic          INTR_O,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready
);

    wb_state_t           state, state_nxt;
    access_t             access;
    logic                req, ack_nxt, err_nxt, pop, flush, push;
    logic [DW-1:0]       dat_nxt;
    logic [DW-1:0]       fifo_head;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_full, fifo_empty, fifo_empty_nxt;
    logic                unused_bits;

    assign unused_bits = ^{DAT_I, SEL_I};
    assign req         = CYC_I & STB_I;

    // Producer is held off while a flush is being decoded so no word is dropped silently.
    assign wr_ready = RST_I & !fifo_full & !flush;
    assign push     = wr_valid & wr_ready;

    always_comb begin
        access = ACC_ILLEGAL;
        if (SEL_I[0]) begin
            if (!WE_I && ADR_I == DATA_ADDR && !fifo_empty) access = ACC_READ_DATA;
            else if (!WE_I && ADR_I == STAT_ADDR)           access = ACC_READ_STAT;
            else if (WE_I && ADR_I == STAT_ADDR)            access = ACC_WRITE_STAT;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        dat_nxt   = DAT_O;
        pop       = 1'b0;
        flush     = 1'b0;
        unique case (state)
            IDLE: if (req) begin
                state_nxt = RESP;
                ack_nxt   = (access != ACC_ILLEGAL);
                err_nxt   = (access == ACC_ILLEGAL);
                case (access)
                    ACC_READ_DATA: begin
                        pop     = 1'b1;
                        dat_nxt = fifo_head;
                    end
                    ACC_READ_STAT:  dat_nxt = DW'(status_word(4'(fifo_count), fifo_full, fifo_empty));
                    ACC_WRITE_STAT: flush = DAT_I[CTRL_FLUSH_BIT];
                    default: ;
                endcase
            end
            RESP:     state_nxt = WAIT_END;
            WAIT_END: if (!req) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state  <= IDLE;
            ACK_O  <= 1'b0;
            ERR_O  <= 1'b0;
            DAT_O  <= '0;
            INTR_O <= 1'b0;
        end else begin
            state  <= state_nxt;
            ACK_O  <= ack_nxt;
            ERR_O  <= err_nxt;
            DAT_O  <= dat_nxt;
            INTR_O <= !fifo_empty_nxt;
        end
    end

    wbslave_fifo_core #(
        .DW         (DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_core (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .push       (push),
        .push_data  (wr_data),
        .pop        (pop),
        .flush      (flush),
        .head_data  (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .empty_nxt  (fifo_empty_nxt)
    );

endmodule

// File: tb/tb_wbslave_fifo.sv
// Directed bench for wbslave_fifo: Wishbone handshakes, FIFO order/full/flush,
// illegal accesses and reset in the middle of a bus cycle.
module tb_wbslave_fifo;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic [7:0] ADR_I = '0;
    logic [7:0] DAT_I = '0;
    logic [7:0] DAT_O;
    logic       WE_I  = 1'b0;
    logic [0:0] SEL_I = '0;
    logic       STB_I = 1'b0;
    logic       CYC_I = 1'b0;
    logic       ACK_O, ERR_O, INTR_O;
    logic [7:0] wr_data  = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    wbslave_fifo dut (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .ADR_I    (ADR_I),
        .DAT_I    (DAT_I),
        .DAT_O    (DAT_O),
        .WE_I     (WE_I),
        .SEL_I    (SEL_I),
        .STB_I    (STB_I),
        .CYC_I    (CYC_I),
        .ACK_O    (ACK_O),
        .ERR_O    (ERR_O),
        .INTR_O   (INTR_O),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready)
    );

    always #5 CLK_I = ~CLK_I;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required normal completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic wb_start(input logic we, input logic [7:0] adr, input logic [7:0] dat, input logic sel);
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = we;
        ADR_I = adr;
        DAT_I = dat;
        SEL_I = sel;
    endtask

    task automatic wb_end();
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        tick();
        tick();
    endtask

    // One strobe held for n_stb edges; response must appear only after the first.
    task automatic wb_xfer(input string tag, input logic we, input logic [7:0] adr,
                           input logic [7:0] dat, input logic sel, input int n_stb,
                           input logic exp_ack, input logic exp_err, input logic [7:0] exp_dat);
        wb_start(we, adr, dat, sel);
        tick();
        check({tag, ".ack"}, ACK_O, exp_ack);
        check({tag, ".err"}, ERR_O, exp_err);
        check({tag, ".dat"}, DAT_O, exp_dat);
        for (int i = 1; i < n_stb; i++) begin
            tick();
            check({tag, ".hold"}, {ACK_O, ERR_O}, 2'b00);
        end
        wb_end();
    endtask

    task automatic stat(input string tag, input logic [7:0] exp);
        wb_xfer(tag, 1'b0, 8'hFE, 8'h00, 1'b1, 1, 1'b1, 1'b0, exp);
    endtask

    task automatic push_word(input logic [7:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        RST_I = 1'b0;
        tick();
        tick();
        check("rst.ack", ACK_O, 1'b0);
        check("rst.err", ERR_O, 1'b0);
        check("rst.dat", DAT_O, 8'h00);
        check("rst.intr", INTR_O, 1'b0);
        check("rst.wr_ready", wr_ready, 1'b0);
        RST_I = 1'b1;
        tick();
        check("post_rst.wr_ready", wr_ready, 1'b1);

        // Read of empty FIFO -> ERR
        wb_xfer("rd_empty", 1'b0, 8'hFF, 8'h00, 1'b1, 1, 1'b0, 1'b1, 8'h00);
        check("rd_empty.intr", INTR_O, 1'b0);

        // Two words, popped with STB held three cycles each
        push_word(8'hA5);
        push_word(8'h3C);
        check("two.intr", INTR_O, 1'b1);
        stat("two.stat", 8'h20);
        wb_xfer("pop1", 1'b0, 8'hFF, 8'h00, 1'b1, 3, 1'b1, 1'b0, 8'hA5);
        check("pop1.intr", INTR_O, 1'b1);
        wb_xfer("pop2", 1'b0, 8'hFF, 8'h00, 1'b1, 3, 1'b1, 1'b0, 8'h3C);
        check("pop2.intr", INTR_O, 1'b0);

        // Fill to full, refused 9th push, pop frees one slot
        for (int i = 0; i < 8; i++) begin
            check("fill.wr_ready", wr_ready, 1'b1);
            push_word(8'h10 + 8'(i));
        end
        check("full.wr_ready", wr_ready, 1'b0);
        stat("full.stat", 8'h82);
        push_word(8'h99);
        stat("full9.stat", 8'h82);
        wb_xfer("full.pop", 1'b0, 8'hFF, 8'h00, 1'b1, 1, 1'b1, 1'b0, 8'h10);
        check("freed.wr_ready", wr_ready, 1'b1);
        push_word(8'h18);
        check("refull.wr_ready", wr_ready, 1'b0);
        stat("refull.stat", 8'h82);
        for (int i = 1; i <= 8; i++)
            wb_xfer("full.order", 1'b0, 8'hFF, 8'h00, 1'b1, 1, 1'b1, 1'b0, 8'h10 + 8'(i));
        stat("drained.stat", 8'h01);

        // Push and pop on the same edge at count 4
        for (int i = 0; i < 4; i++) push_word(8'h40 + 8'(i));
        stat("four.stat", 8'h40);
        wr_data  = 8'h44;
        wr_valid = 1'b1;
        wb_start(1'b0, 8'hFF, 8'h00, 1'b1);
        tick();
        wr_valid = 1'b0;
        check("same.ack", ACK_O, 1'b1);
        check("same.dat", DAT_O, 8'h40);
        wb_end();
        stat("same.stat", 8'h40);
        for (int i = 1; i <= 4; i++)
            wb_xfer("same.order", 1'b0, 8'hFF, 8'h00, 1'b1, 1, 1'b1, 1'b0, 8'h40 + 8'(i));

        // Twenty words across several pointer wraps
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 5; j++) push_word(8'h60 + 8'(5 * b + j));
            for (int j = 0; j < 5; j++)
                wb_xfer("wrap.order", 1'b0, 8'hFF, 8'h00, 1'b1, 1, 1'b1, 1'b0, 8'h60 + 8'(5 * b + j));
        end

        // Flush with a producer word presented on the flush edge
        for (int i = 0; i < 5; i++) push_word(8'h80 + 8'(i));
        stat("five.stat", 8'h50);
        wr_data  = 8'hEE;
        wr_valid = 1'b1;
        wb_start(1'b1, 8'hFE, 8'h01, 1'b1);
        #1;
        check("flush.wr_ready", wr_ready, 1'b0);
        tick();
        wr_valid = 1'b0;
        check("flush.ack", ACK_O, 1'b1);
        check("flush.err", ERR_O, 1'b0);
        check("flush.dat", DAT_O, 8'h50);
        wb_end();
        stat("flush.stat", 8'h01);
        check("flush.intr", INTR_O, 1'b0);
        push_word(8'h55);
        wb_xfer("ctrl0", 1'b1, 8'hFE, 8'h00, 1'b1, 1, 1'b1, 1'b0, 8'h01);
        stat("ctrl0.stat", 8'h10);

        // Illegal accesses leave FIFO and DAT_O untouched
        wb_xfer("wr_data", 1'b1, 8'hFF, 8'h77, 1'b1, 1, 1'b0, 1'b1, 8'h10);
        wb_xfer("rd_bad", 1'b0, 8'h10, 8'h00, 1'b1, 1, 1'b0, 1'b1, 8'h10);
        wb_xfer("rd_sel0", 1'b0, 8'hFF, 8'h00, 1'b0, 1, 1'b0, 1'b1, 8'h10);
        stat("illegal.stat", 8'h10);
        wb_xfer("illegal.pop", 1'b0, 8'hFF, 8'h00, 1'b1, 1, 1'b1, 1'b0, 8'h55);

        // Reset asserted during WAIT_END
        push_word(8'h66);
        push_word(8'h67);
        wb_start(1'b0, 8'hFF, 8'h00, 1'b1);
        tick();
        check("mid.ack", ACK_O, 1'b1);
        check("mid.dat", DAT_O, 8'h66);
        tick();
        RST_I = 1'b0;
        #1;
        check("mid_rst.ack", ACK_O, 1'b0);
        check("mid_rst.err", ERR_O, 1'b0);
        check("mid_rst.dat", DAT_O, 8'h00);
        check("mid_rst.intr", INTR_O, 1'b0);
        check("mid_rst.wr_ready", wr_ready, 1'b0);
        CYC_I = 1'b0;
        STB_I = 1'b0;
        tick();
        RST_I = 1'b1;
        tick();
        stat("mid_rst.stat", 8'h01);
        wb_xfer("mid_rst.rd", 1'b0, 8'hFF, 8'h00, 1'b1, 1, 1'b0, 1'b1, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
